// File: rtl/vga_must_pkg.sv
// Shared timing constants and RGB565 layout for the VGA controller slice.
package vga_must_pkg;

    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;

    localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int unsigned VGA_H_START = VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_START = VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned PIX_X_W = 10;
    localparam int unsigned PIX_Y_W = 9;

    localparam int unsigned R_W   = 5;
    localparam int unsigned G_W   = 6;
    localparam int unsigned B_W   = 5;
    localparam int unsigned RGB_W = R_W + G_W + B_W;
    localparam int unsigned R_LSB = G_W + B_W;
    localparam int unsigned G_LSB = B_W;
    localparam int unsigned B_LSB = 0;

    function automatic logic [RGB_W-1:0] rgb565_pack(input logic [R_W-1:0] r,
                                                     input logic [G_W-1:0] g,
                                                     input logic [B_W-1:0] b);
        logic [RGB_W-1:0] p;
        p = '0;
        p[R_LSB +: R_W] = r;
        p[G_LSB +: G_W] = g;
        p[B_LSB +: B_W] = b;
        return p;
    endfunction

endpackage

// File: rtl/vga_ctrl_must_if.sv
// Picture-source request/response and display-side signals of the VGA controller.
interface vga_ctrl_must_if;
    import vga_must_pkg::*;

    logic [RGB_W-1:0]   pix_data;
    logic [PIX_X_W-1:0] pix_x;
    logic [PIX_Y_W-1:0] pix_y;
    logic               pix_req;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [RGB_W-1:0]   rgb;
    logic               frame_start;

    modport master (
        input  pix_data,
        output pix_x, pix_y, pix_req, hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, pix_req, hsync, vsync, de, rgb, frame_start
    );

endinterface

// File: rtl/vga_timing_cnt_must.sv
// Horizontal/vertical raster counters; v_cnt advances only on the h_cnt wrap.
module vga_timing_cnt_must #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned HW      = $clog2(H_TOTAL),
    parameter int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_end
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    assign line_end = (h_cnt == H_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/vga_ctrl_must.sv
// VGA timing generator and pixel fetcher: issues pix_x/pix_y ahead of the visible
// window by PIX_LAT clocks and registers sync, data-enable and rgb in one aligned stage.
module vga_ctrl_must #(
    parameter int unsigned H_SYNC   = vga_must_pkg::VGA_H_SYNC,
    parameter int unsigned H_BACK   = vga_must_pkg::VGA_H_BACK,
    parameter int unsigned H_ACTIVE = vga_must_pkg::VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = vga_must_pkg::VGA_H_FRONT,
    parameter int unsigned V_SYNC   = vga_must_pkg::VGA_V_SYNC,
    parameter int unsigned V_BACK   = vga_must_pkg::VGA_V_BACK,
    parameter int unsigned V_ACTIVE = vga_must_pkg::VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = vga_must_pkg::VGA_V_FRONT,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic            vga_clk,
    input  logic            sys_rst,
    vga_ctrl_must_if.master vga
);
    import vga_must_pkg::*;

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    // The request must stay inside the back porch so it never spills into the previous line.
    if (PIX_LAT < 1 || PIX_LAT > H_BACK) begin : g_pix_lat_range
        $error("vga_ctrl_must: PIX_LAT must be in 1..H_BACK");
    end

    localparam logic [HW-1:0] REQ_H_LO = HW'(H_START - PIX_LAT);
    localparam logic [HW-1:0] REQ_H_HI = HW'(H_START + H_ACTIVE - PIX_LAT);
    localparam logic [HW-1:0] ACT_H_LO = HW'(H_START);
    localparam logic [HW-1:0] ACT_H_HI = HW'(H_START + H_ACTIVE);
    localparam logic [HW-1:0] HS_END   = HW'(H_SYNC);
    localparam logic [VW-1:0] ACT_V_LO = VW'(V_START);
    localparam logic [VW-1:0] ACT_V_HI = VW'(V_START + V_ACTIVE);
    localparam logic [VW-1:0] VS_END   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end;

    vga_timing_cnt_must #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_cnt (
        .clk      (vga_clk),
        .rst      (sys_rst),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .line_end (line_end)
    );

    logic          v_in;
    logic          req;
    logic          active;
    logic [HW-1:0] x_off;
    logic [VW-1:0] y_off;

    always_comb begin
        v_in   = (v_cnt >= ACT_V_LO) && (v_cnt < ACT_V_HI);
        req    = v_in && (h_cnt >= REQ_H_LO) && (h_cnt < REQ_H_HI);
        active = v_in && (h_cnt >= ACT_H_LO) && (h_cnt < ACT_H_HI);
        x_off  = h_cnt - REQ_H_LO;
        y_off  = v_cnt - ACT_V_LO;
    end

    assign vga.pix_req = req;
    assign vga.pix_x   = req ? PIX_X_W'(x_off) : '0;
    assign vga.pix_y   = req ? PIX_Y_W'(y_off) : '0;

    logic             hsync_q;
    logic             vsync_q;
    logic             de_q;
    logic [RGB_W-1:0] rgb_q;
    logic             frame_start_q;
    // Set exactly when the counters sit at (0,0), avoiding a full-width compare.
    logic             origin_q;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            origin_q      <= 1'b1;
        end else begin
            hsync_q       <= ~(h_cnt < HS_END);
            vsync_q       <= ~(v_cnt < VS_END);
            de_q          <= active;
            rgb_q         <= active ? vga.pix_data : '0;
            frame_start_q <= origin_q;
            origin_q      <= line_end && (v_cnt == V_LAST);
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.rgb         = rgb_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl_must.sv
// Bench for vga_ctrl_must: full 640x480 instance plus a shrunken raster with PIX_LAT = 3.
module tb_vga_ctrl_must;
    import vga_must_pkg::*;

    // Shrunken raster B: 28 clocks per line, 13 lines, 364 clocks per frame.
    localparam int B_HSY = 4, B_HBK = 4, B_HAC = 16, B_HFR = 4;
    localparam int B_VSY = 2, B_VBK = 3, B_VAC = 6, B_VFR = 2, B_LAT = 3;
    localparam int B_HT = B_HSY + B_HBK + B_HAC + B_HFR;
    localparam int B_FRAME = B_HT * (B_VSY + B_VBK + B_VAC + B_VFR);

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #20 clk = ~clk;

    vga_ctrl_must_if ifa ();
    vga_ctrl_must_if ifb ();

    vga_ctrl_must #(
        .H_SYNC (96), .H_BACK (48), .H_ACTIVE (640), .H_FRONT (16),
        .V_SYNC (2), .V_BACK (33), .V_ACTIVE (480), .V_FRONT (10), .PIX_LAT (1)
    ) dut_a (
        .vga_clk (clk),
        .sys_rst (rst_a),
        .vga     (ifa.master)
    );

    vga_ctrl_must #(
        .H_SYNC (B_HSY), .H_BACK (B_HBK), .H_ACTIVE (B_HAC), .H_FRONT (B_HFR),
        .V_SYNC (B_VSY), .V_BACK (B_VBK), .V_ACTIVE (B_VAC), .V_FRONT (B_VFR),
        .PIX_LAT (B_LAT)
    ) dut_b (
        .vga_clk (clk),
        .sys_rst (rst_b),
        .vga     (ifb.master)
    );

    function automatic logic [15:0] pix_model(input logic [9:0] x, input logic [8:0] y);
        return rgb565_pack(x[4:0], y[5:0], x[9:5]);
    endfunction

    // Picture sources: 1-clock latency for A, 3-clock pipeline for B.
    logic [15:0] src_a, src_b1, src_b2, src_b3;
    always @(posedge clk) begin
        src_a  <= pix_model(ifa.pix_x, ifa.pix_y);
        src_b1 <= pix_model(ifb.pix_x, ifb.pix_y);
        src_b2 <= src_b1;
        src_b3 <= src_b2;
    end
    assign ifa.pix_data = src_a;
    assign ifb.pix_data = src_b3;

    // Clock edges seen since reset release; position in the raster follows from this alone.
    int a_t, b_t;
    always @(posedge clk or posedge rst_a) if (rst_a) a_t <= 0; else a_t <= a_t + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) b_t <= 0; else b_t <= b_t + 1;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int checks = 0;
    int errors = 0;
    bit done = 0;

    task automatic finish_run();
        if (!done) begin
            done = 1;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    endtask

    // Scoreboard: expected pixels are queued when a request is issued and popped on de.
    task automatic sb_step(input int d);
        int hsy, hbk, hac, vsy, vbk, vac, lat, ht, vt, hs, vs, t, h, v, ph, pv;
        logic rst, req_e, act_e;
        logic [9:0] ex;
        logic [8:0] ey;
        logic [19:0] got_req, exp_req;
        logic [3:0] got_ctl, exp_ctl;
        logic [15:0] got_rgb, exp_rgb;
        if (d == 0) begin
            hsy = VGA_H_SYNC; hbk = VGA_H_BACK; hac = VGA_H_ACTIVE;
            vsy = VGA_V_SYNC; vbk = VGA_V_BACK; vac = VGA_V_ACTIVE; lat = 1;
            ht = VGA_H_TOTAL; vt = VGA_V_TOTAL; rst = rst_a; t = a_t;
            got_req = {ifa.pix_req, ifa.pix_x, ifa.pix_y};
            got_ctl = {ifa.hsync, ifa.vsync, ifa.de, ifa.frame_start};
            got_rgb = ifa.rgb;
        end else begin
            hsy = B_HSY; hbk = B_HBK; hac = B_HAC;
            vsy = B_VSY; vbk = B_VBK; vac = B_VAC; lat = B_LAT;
            ht = B_HT; vt = B_FRAME / B_HT; rst = rst_b; t = b_t;
            got_req = {ifb.pix_req, ifb.pix_x, ifb.pix_y};
            got_ctl = {ifb.hsync, ifb.vsync, ifb.de, ifb.frame_start};
            got_rgb = ifb.rgb;
        end
        hs = hsy + hbk;
        vs = vsy + vbk;
        exp_req = '0;
        exp_ctl = 4'b1100;
        exp_rgb = '0;
        if (rst) begin
            if (d == 0) q_a.delete(); else q_b.delete();
        end else if (t > 0) begin
            h = t % ht;
            v = (t / ht) % vt;
            req_e = (v >= vs) && (v < vs + vac) && (h >= hs - lat) && (h < hs + hac - lat);
            ex = req_e ? 10'(h - (hs - lat)) : 10'd0;
            ey = req_e ? 9'(v - vs) : 9'd0;
            exp_req = {req_e, ex, ey};
            if (req_e) begin
                if (d == 0) q_a.push_back(pix_model(ex, ey));
                else q_b.push_back(pix_model(ex, ey));
            end
            ph = (t - 1) % ht;
            pv = ((t - 1) / ht) % vt;
            act_e = (ph >= hs) && (ph < hs + hac) && (pv >= vs) && (pv < vs + vac);
            exp_ctl = {!(ph < hsy), !(pv < vsy), act_e, (ph == 0) && (pv == 0)};
            if (act_e) begin
                if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL sb_empty_%0d: rgb %h with no queued pixel", d, got_rgb);
                end else begin
                    exp_rgb = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                end
            end
        end
        checks++;
        if (got_req !== exp_req) begin
            errors++;
            $display("FAIL sb_req_xy_%0d t=%0d: got %h, required %h", d, t, got_req, exp_req);
        end
        checks++;
        if (got_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL sb_hs_vs_de_fs_%0d t=%0d: got %b, required %b", d, t, got_ctl, exp_ctl);
        end
        checks++;
        if (got_rgb !== exp_rgb) begin
            errors++;
            $display("FAIL sb_rgb_%0d t=%0d: got %h, required %h", d, t, got_rgb, exp_rgb);
        end
        if (errors > 100) finish_run();
    endtask

    always @(negedge clk) begin
        sb_step(0);
        sb_step(1);
    end

    task automatic wait_a(input int target);
        int budget = target - a_t + 10;
        for (int i = 0; i < budget && a_t != target; i++) @(negedge clk);
        checks++;
        if (a_t != target) begin
            errors++;
            $display("FAIL wait_a: reached t=%0d, required t=%0d", a_t, target);
        end
    endtask

    task automatic wait_b_mod(input int target);
        for (int i = 0; i < 2 * B_FRAME && (b_t % B_FRAME) != target; i++) @(negedge clk);
        checks++;
        if ((b_t % B_FRAME) != target) begin
            errors++;
            $display("FAIL wait_b: reached %0d, required %0d", b_t % B_FRAME, target);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks += 4;
        if ({ifa.pix_req, ifa.pix_x, ifa.pix_y} !== 20'h0) begin
            errors++; $display("FAIL rst_req_a: got %h, required 0", {ifa.pix_req, ifa.pix_x, ifa.pix_y});
        end
        if ({ifa.hsync, ifa.vsync, ifa.de, ifa.frame_start, ifa.rgb} !== {4'b1100, 16'h0}) begin
            errors++; $display("FAIL rst_out_a: got %b_%h, required 1100_0000",
                               {ifa.hsync, ifa.vsync, ifa.de, ifa.frame_start}, ifa.rgb);
        end
        if ({ifb.pix_req, ifb.pix_x, ifb.pix_y} !== 20'h0) begin
            errors++; $display("FAIL rst_req_b: got %h, required 0", {ifb.pix_req, ifb.pix_x, ifb.pix_y});
        end
        if ({ifb.hsync, ifb.vsync, ifb.de, ifb.frame_start, ifb.rgb} !== {4'b1100, 16'h0}) begin
            errors++; $display("FAIL rst_out_b: got %b_%h, required 1100_0000",
                               {ifb.hsync, ifb.vsync, ifb.de, ifb.frame_start}, ifb.rgb);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if ({ifa.frame_start, ifa.hsync} !== 2'b10) begin
            errors++; $display("FAIL first_edge_a: fs,hsync got %b, required 10", {ifa.frame_start, ifa.hsync});
        end
        if ({ifb.frame_start, ifb.hsync} !== 2'b10) begin
            errors++; $display("FAIL first_edge_b: fs,hsync got %b, required 10", {ifb.frame_start, ifb.hsync});
        end
    endtask

    // Window starts with registered position (0,0) already on the outputs.
    task automatic test_frame_sync_a();
        int vlow, hlow, decnt, fs;
        vlow = 0; hlow = 0; decnt = 0; fs = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (!ifa.vsync) vlow++;
            if (!ifa.hsync && i < 800) hlow++;
            if (ifa.de) decnt++;
            if (ifa.frame_start) fs++;
        end
        checks += 4;
        if (vlow != 1600) begin errors++; $display("FAIL vsync_low: got %0d, required 1600", vlow); end
        if (hlow != 96) begin errors++; $display("FAIL hsync_low_line0: got %0d, required 96", hlow); end
        if (decnt != 0) begin errors++; $display("FAIL de_in_vblank: got %0d, required 0", decnt); end
        if (fs != 1) begin errors++; $display("FAIL frame_start_count: got %0d, required 1", fs); end
    endtask

    task automatic test_first_pixel_a();
        wait_a(35 * 800 + 142);
        checks++;
        if (ifa.pix_req !== 1'b0) begin errors++; $display("FAIL req_early: got %b, required 0", ifa.pix_req); end
        @(negedge clk);
        checks++;
        if ({ifa.pix_req, ifa.pix_x, ifa.pix_y} !== {1'b1, 10'd0, 9'd0}) begin
            errors++; $display("FAIL req_first: got %h, required %h",
                               {ifa.pix_req, ifa.pix_x, ifa.pix_y}, {1'b1, 19'd0});
        end
        @(negedge clk);
        checks++;
        if (ifa.de !== 1'b0) begin errors++; $display("FAIL de_early: got %b, required 0", ifa.de); end
        @(negedge clk);
        checks++;
        if ({ifa.de, ifa.rgb} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL first_pixel: de,rgb got %b,%h, required 1,0000", ifa.de, ifa.rgb);
        end
        @(negedge clk);
        checks++;
        if (ifa.rgb !== 16'h0800) begin errors++; $display("FAIL pixel_1_0: got %h, required 0800", ifa.rgb); end
    endtask

    task automatic test_line_timing_a();
        int hlow, decnt, rises, maxx;
        logic prev_de;
        hlow = 0; decnt = 0; rises = 0; maxx = 0; prev_de = 1'b0;
        wait_a(36 * 800 + 1);
        for (int i = 0; i < 1600; i++) begin
            if (!ifa.hsync) hlow++;
            if (ifa.de) decnt++;
            if (ifa.de && !prev_de) rises++;
            prev_de = ifa.de;
            if (int'(ifa.pix_x) > maxx) maxx = int'(ifa.pix_x);
            @(negedge clk);
        end
        checks += 4;
        if (hlow != 192) begin errors++; $display("FAIL hsync_low_2lines: got %0d, required 192", hlow); end
        if (decnt != 1280) begin errors++; $display("FAIL de_2lines: got %0d, required 1280", decnt); end
        if (rises != 2) begin errors++; $display("FAIL de_runs: got %0d, required 2", rises); end
        if (maxx != 639) begin errors++; $display("FAIL max_pix_x: got %0d, required 639", maxx); end
    endtask

    task automatic test_pixel_141_39_a();
        wait_a(74 * 800 + 286);
        checks++;
        if ({ifa.de, ifa.rgb} !== {1'b1, 16'h6CE4}) begin
            errors++; $display("FAIL pixel_141_39: de,rgb got %b,%h, required 1,6ce4", ifa.de, ifa.rgb);
        end
    endtask

    task automatic test_frame_b();
        int n, lines, vlow;
        logic prev_hs;
        n = 0;
        while (!ifb.frame_start && n < 2 * B_FRAME) begin @(posedge clk); #1; n++; end
        n = 0; lines = 0; vlow = 0; prev_hs = ifb.hsync;
        do begin
            @(posedge clk); #1;
            n++;
            if (prev_hs && !ifb.hsync) lines++;
            prev_hs = ifb.hsync;
            if (!ifb.vsync) vlow++;
        end while (!ifb.frame_start && n < 2 * B_FRAME);
        checks += 3;
        if (n != B_FRAME) begin errors++; $display("FAIL frame_period_b: got %0d, required %0d", n, B_FRAME); end
        if (lines != 13) begin errors++; $display("FAIL lines_per_frame_b: got %0d, required 13", lines); end
        if (vlow != 2 * B_HT) begin errors++; $display("FAIL vsync_low_b: got %0d, required %0d", vlow, 2 * B_HT); end
    endtask

    task automatic test_lat3_b();
        wait_b_mod(5 * B_HT + 4);
        checks++;
        if (ifb.pix_req !== 1'b0) begin errors++; $display("FAIL lat3_req_early: got %b, required 0", ifb.pix_req); end
        @(negedge clk);
        checks++;
        if ({ifb.pix_req, ifb.pix_x, ifb.pix_y} !== {1'b1, 19'd0}) begin
            errors++; $display("FAIL lat3_req_first: got %h, required %h",
                               {ifb.pix_req, ifb.pix_x, ifb.pix_y}, {1'b1, 19'd0});
        end
        wait_b_mod(6 * B_HT + 9);
        checks++;
        if ({ifb.de, ifb.rgb} !== {1'b1, 16'h0020}) begin
            errors++; $display("FAIL lat3_pixel_0_1: de,rgb got %b,%h, required 1,0020", ifb.de, ifb.rgb);
        end
        @(negedge clk);
        checks++;
        if (ifb.rgb !== 16'h0820) begin errors++; $display("FAIL lat3_pixel_1_1: got %h, required 0820", ifb.rgb); end
    endtask

    task automatic test_mid_reset_b();
        wait_b_mod(7 * B_HT + 15);
        #5 rst_b = 1'b1;
        #1;
        checks += 2;
        if ({ifb.pix_req, ifb.pix_x, ifb.pix_y} !== 20'h0) begin
            errors++; $display("FAIL midrst_req: got %h, required 0", {ifb.pix_req, ifb.pix_x, ifb.pix_y});
        end
        if ({ifb.hsync, ifb.vsync, ifb.de, ifb.frame_start, ifb.rgb} !== {4'b1100, 16'h0}) begin
            errors++; $display("FAIL midrst_out: got %b_%h, required 1100_0000",
                               {ifb.hsync, ifb.vsync, ifb.de, ifb.frame_start}, ifb.rgb);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ifb.frame_start, ifb.hsync} !== 2'b10) begin
            errors++; $display("FAIL midrst_release: fs,hsync got %b, required 10", {ifb.frame_start, ifb.hsync});
        end
        wait_b_mod(5 * B_HT + 10);
        checks++;
        if ({ifb.de, ifb.rgb} !== {1'b1, 16'h0800}) begin
            errors++; $display("FAIL midrst_pixel_1_0: de,rgb got %b,%h, required 1,0800", ifb.de, ifb.rgb);
        end
    endtask

    initial begin
        test_reset();
        test_frame_sync_a();
        test_first_pixel_a();
        test_line_timing_a();
        test_pixel_141_39_a();
        test_frame_b();
        test_lat3_b();
        test_mid_reset_b();
        repeat (2 * B_FRAME) @(negedge clk);
        finish_run();
    end

endmodule
